// File: rtl/mem_if_axi_master_bridge_if.sv
// AXI4 bus bundle connecting the memory bridge (master) to a crossbar/slave.
interface AXI_BUS #(
   parameter int unsigned AXI_ADDR_WIDTH = 32,
   parameter int unsigned AXI_DATA_WIDTH = 64,
   parameter int unsigned AXI_ID_WIDTH   = 10,
   parameter int unsigned AXI_USER_WIDTH = 1
);
   localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;

   logic [AXI_ID_WIDTH-1:0]   aw_id;
   logic [AXI_ADDR_WIDTH-1:0] aw_addr;
   logic [7:0]                aw_len;
   logic [2:0]                aw_size;
   logic [1:0]                aw_burst;
   logic                      aw_lock;
   logic [3:0]                aw_cache;
   logic [2:0]                aw_prot;
   logic [3:0]                aw_qos;
   logic [3:0]                aw_region;
   logic [AXI_USER_WIDTH-1:0] aw_user;
   logic                      aw_valid;
   logic                      aw_ready;

   logic [AXI_DATA_WIDTH-1:0] w_data;
   logic [STRB_W-1:0]         w_strb;
   logic                      w_last;
   logic [AXI_USER_WIDTH-1:0] w_user;
   logic                      w_valid;
   logic                      w_ready;

   logic [AXI_ID_WIDTH-1:0]   b_id;
   logic [1:0]                b_resp;
   logic [AXI_USER_WIDTH-1:0] b_user;
   logic                      b_valid;
   logic                      b_ready;

   logic [AXI_ID_WIDTH-1:0]   ar_id;
   logic [AXI_ADDR_WIDTH-1:0] ar_addr;
   logic [7:0]                ar_len;
   logic [2:0]                ar_size;
   logic [1:0]                ar_burst;
   logic                      ar_lock;
   logic [3:0]                ar_cache;
   logic [2:0]                ar_prot;
   logic [3:0]                ar_qos;
   logic [3:0]                ar_region;
   logic [AXI_USER_WIDTH-1:0] ar_user;
   logic                      ar_valid;
   logic                      ar_ready;

   logic [AXI_ID_WIDTH-1:0]   r_id;
   logic [AXI_DATA_WIDTH-1:0] r_data;
   logic [1:0]                r_resp;
   logic                      r_last;
   logic [AXI_USER_WIDTH-1:0] r_user;
   logic                      r_valid;
   logic                      r_ready;

   modport Master (
      output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
             aw_qos, aw_region, aw_user, aw_valid,
      input  aw_ready,
      output w_data, w_strb, w_last, w_user, w_valid,
      input  w_ready,
      input  b_id, b_resp, b_user, b_valid,
      output b_ready,
      output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
             ar_qos, ar_region, ar_user, ar_valid,
      input  ar_ready,
      input  r_id, r_data, r_resp, r_last, r_user, r_valid,
      output r_ready
   );

   modport Slave (
      input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
             aw_qos, aw_region, aw_user, aw_valid,
      output aw_ready,
      input  w_data, w_strb, w_last, w_user, w_valid,
      output w_ready,
      output b_id, b_resp, b_user, b_valid,
      input  b_ready,
      input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
             ar_qos, ar_region, ar_user, ar_valid,
      output ar_ready,
      output r_id, r_data, r_resp, r_last, r_user, r_valid,
      input  r_ready
   );
endinterface

// File: rtl/mem_if_axi_master_bridge.sv
// Core-style req/gnt/rvalid port to single-beat AXI4 master, one transaction in flight.
module mem_if_axi_master_bridge #(
   parameter int unsigned AXI_ADDR_WIDTH = 32,
   parameter int unsigned AXI_DATA_WIDTH = 64,
   parameter int unsigned AXI_ID_WIDTH   = 10,
   parameter int unsigned AXI_USER_WIDTH = 1,
   parameter logic [AXI_ID_WIDTH-1:0] AXI_ID = '0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        mem_req_i,
   output logic                        mem_gnt_o,
   input  logic [AXI_ADDR_WIDTH-1:0]   mem_addr_i,
   input  logic                        mem_we_i,
   input  logic [AXI_DATA_WIDTH/8-1:0] mem_be_i,
   input  logic [AXI_DATA_WIDTH-1:0]   mem_wdata_i,
   output logic                        mem_rvalid_o,
   output logic [AXI_DATA_WIDTH-1:0]   mem_rdata_o,
   output logic                        mem_err_o,
   AXI_BUS.Master                      master
);
   localparam int unsigned STRB_W   = AXI_DATA_WIDTH / 8;
   localparam logic [2:0]  AXI_SIZE = 3'($clog2(STRB_W));

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_e;

   state_e                    state_q, state_d;
   logic                      aw_valid_q, aw_valid_d;
   logic                      w_valid_q, w_valid_d;
   logic                      ar_valid_q, ar_valid_d;
   logic                      b_ready_q, b_ready_d;
   logic                      r_ready_q, r_ready_d;
   logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [STRB_W-1:0]         be_q, be_d;
   logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                      rvalid_q, rvalid_d;
   logic                      err_q, err_d;
   logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                      aw_done, w_done;

   // Grant is only ever given from IDLE; suppressed while reset is held
   assign mem_gnt_o    = (state_q == IDLE) && mem_req_i && !rst;
   assign mem_rvalid_o = rvalid_q;
   assign mem_rdata_o  = rdata_q;
   assign mem_err_o    = err_q;

   // AW/AR share the latched address; all AXI outputs come from flops or constants
   assign master.aw_id     = AXI_ID;
   assign master.aw_addr   = addr_q;
   assign master.aw_len    = 8'd0;
   assign master.aw_size   = AXI_SIZE;
   assign master.aw_burst  = 2'b01;
   assign master.aw_lock   = 1'b0;
   assign master.aw_cache  = 4'd0;
   assign master.aw_prot   = 3'd0;
   assign master.aw_qos    = 4'd0;
   assign master.aw_region = 4'd0;
   assign master.aw_user   = '0;
   assign master.aw_valid  = aw_valid_q;

   assign master.w_data    = wdata_q;
   assign master.w_strb    = be_q;
   assign master.w_last    = 1'b1;
   assign master.w_user    = '0;
   assign master.w_valid   = w_valid_q;

   assign master.b_ready   = b_ready_q;

   assign master.ar_id     = AXI_ID;
   assign master.ar_addr   = addr_q;
   assign master.ar_len    = 8'd0;
   assign master.ar_size   = AXI_SIZE;
   assign master.ar_burst  = 2'b01;
   assign master.ar_lock   = 1'b0;
   assign master.ar_cache  = 4'd0;
   assign master.ar_prot   = 3'd0;
   assign master.ar_qos    = 4'd0;
   assign master.ar_region = 4'd0;
   assign master.ar_user   = '0;
   assign master.ar_valid  = ar_valid_q;

   assign master.r_ready   = r_ready_q;

   // Response IDs, users, r_last and low resp bits carry nothing we act on
   logic unused_inputs;
   assign unused_inputs = ^{master.b_id, master.b_user, master.b_resp[0],
                            master.r_id, master.r_user, master.r_resp[0], master.r_last};

   // A write channel counts as done once its valid has already dropped or handshakes now
   assign aw_done = !aw_valid_q || master.aw_ready;
   assign w_done  = !w_valid_q  || master.w_ready;

   // Next-state and datapath: one request latched in IDLE, walked through AXI, reported once
   always_comb begin
      state_d    = state_q;
      aw_valid_d = aw_valid_q;
      w_valid_d  = w_valid_q;
      ar_valid_d = ar_valid_q;
      b_ready_d  = b_ready_q;
      r_ready_d  = r_ready_q;
      addr_d     = addr_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      rvalid_d   = 1'b0;
      err_d      = err_q;
      rdata_d    = rdata_q;
      unique case (state_q)
         IDLE: begin
            if (mem_req_i) begin
               addr_d  = mem_addr_i;
               be_d    = mem_be_i;
               wdata_d = mem_wdata_i;
               if (mem_we_i) begin
                  aw_valid_d = 1'b1;
                  w_valid_d  = 1'b1;
                  state_d    = WR_REQ;
               end else begin
                  ar_valid_d = 1'b1;
                  state_d    = RD_REQ;
               end
            end
         end
         WR_REQ: begin
            // AW and W retire independently; neither waits on the other
            if (aw_valid_q && master.aw_ready) aw_valid_d = 1'b0;
            if (w_valid_q && master.w_ready)   w_valid_d  = 1'b0;
            if (aw_done && w_done) begin
               b_ready_d = 1'b1;
               state_d   = WR_RESP;
            end
         end
         WR_RESP: begin
            if (master.b_valid && b_ready_q) begin
               rvalid_d  = 1'b1;
               err_d     = master.b_resp[1];
               b_ready_d = 1'b0;
               state_d   = IDLE;
            end
         end
         RD_REQ: begin
            if (ar_valid_q && master.ar_ready) begin
               ar_valid_d = 1'b0;
               r_ready_d  = 1'b1;
               state_d    = RD_RESP;
            end
         end
         RD_RESP: begin
            // Single beat: r_last is not consulted
            if (master.r_valid && r_ready_q) begin
               rvalid_d  = 1'b1;
               rdata_d   = master.r_data;
               err_d     = master.r_resp[1];
               r_ready_d = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset abandons any transaction silently
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         aw_valid_q <= 1'b0;
         w_valid_q  <= 1'b0;
         ar_valid_q <= 1'b0;
         b_ready_q  <= 1'b0;
         r_ready_q  <= 1'b0;
         addr_q     <= '0;
         be_q       <= '0;
         wdata_q    <= '0;
         rvalid_q   <= 1'b0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         aw_valid_q <= aw_valid_d;
         w_valid_q  <= w_valid_d;
         ar_valid_q <= ar_valid_d;
         b_ready_q  <= b_ready_d;
         r_ready_q  <= r_ready_d;
         addr_q     <= addr_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         rvalid_q   <= rvalid_d;
         err_q      <= err_d;
         rdata_q    <= rdata_d;
      end
   end
endmodule

// File: doc/mem_if_axi_master_bridge.md
Name: mem_if_axi_master_bridge

Overview:
- Converts a single-port core-style memory request interface (req/gnt/rvalid) into single-beat AXI4 master transactions.
- It is the initiator counterpart to the SRAM-side AXI slave bridge and is placed between a core/DMA port and the AXI crossbar.
- At most one transaction is outstanding.
- Writes complete on the B handshake and reads complete on the R handshake. Each completion is reported with a one-cycle mem_rvalid_o.

Parameters:
- AXI_ADDR_WIDTH, 32, AXI and memory address width.
- AXI_DATA_WIDTH, 64, AXI and memory data width; power of two, at least 32.
- AXI_ID_WIDTH, 10, AXI ID width.
- AXI_USER_WIDTH, 1, AXI user width.
- AXI_ID, 0, constant ID driven on aw_id and ar_id.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_req_i  in  1  request valid
- mem_gnt_o  out  1  request accepted this cycle
- mem_addr_i  in  AXI_ADDR_WIDTH  byte address
- mem_we_i  in  1  1 = write, 0 = read
- mem_be_i  in  AXI_DATA_WIDTH/8  byte enables
- mem_wdata_i  in  AXI_DATA_WIDTH  write data
- mem_rvalid_o  out  1  completion pulse (read data or write ack)
- mem_rdata_o  out  AXI_DATA_WIDTH  read data, valid with mem_rvalid_o
- mem_err_o  out  1  bresp/rresp[1] set, valid with mem_rvalid_o
- master  AXI_BUS.Master  -  AXI4 master port

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, rst. On reset the FSM goes to IDLE and the following registers clear to 0: aw_valid, w_valid, ar_valid, b_ready, r_ready, mem_gnt_o, mem_rvalid_o, mem_err_o and mem_rdata_o. Reset mid-transaction abandons the transaction with no completion pulse.
- Constant AXI fields:
  - len = 0, size = log2(AXI_DATA_WIDTH/8), burst = 2'b01.
  - lock, cache, prot, region, qos and all user fields = 0.
  - id = AXI_ID, w_last = 1.
- All AXI outputs are driven from registers. No combinational path exists from mem_* inputs to AXI outputs.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
- IDLE:
  - mem_gnt_o = mem_req_i, combinational. Granting happens only in IDLE.
  - On mem_req_i, latch addr, be and wdata.
  - If we = 1: set aw_valid and w_valid, go to WR_REQ.
  - If we = 0: set ar_valid, go to RD_REQ.
  - The AXI valids assert in the cycle after the grant.
- WR_REQ:
  - aw and w are sent independently. Each valid drops in the cycle after its own handshake, and stays high until then even if the other channel completes first.
  - When both have completed (same or different cycles), raise b_ready and go to WR_RESP.
  - W is never withheld waiting for AW.
- WR_RESP:
  - On b_valid && b_ready: one-cycle mem_rvalid_o, mem_err_o = b_resp[1], mem_rdata_o unchanged.
  - Drop b_ready and go to IDLE.
- RD_REQ: on ar handshake, drop ar_valid, raise r_ready, go to RD_RESP.
- RD_RESP:
  - On r_valid && r_ready: one-cycle mem_rvalid_o, mem_rdata_o = r_data registered, mem_err_o = r_resp[1].
  - Drop r_ready and go to IDLE.
  - r_last is ignored and treated as 1.
- Latency:
  - mem_rvalid_o is registered and asserts the cycle after the B/R handshake.
  - With zero-wait slave readiness, grant to rvalid is 4 cycles: grant, valid/handshake, response handshake, rvalid.
  - The next grant is possible in the same cycle mem_rvalid_o asserts, since the FSM is back in IDLE.
- mem_rdata_o holds its last read value until the next read completes.
- Unexpected b_valid or r_valid outside the wait states is ignored (ready = 0).
- mem_req_i deasserted while not in IDLE has no effect.
- Address is passed unmodified; no alignment check.

Test Plan:
- Read: req addr 0x1000_0008, we = 0, slave ar_ready = 1, r_data = 0xDEAD_BEEF_0123_4567, rresp = 0 → ar_addr = 0x1000_0008, ar_len = 0, ar_size = 3, ar_burst = 1. One mem_rvalid_o pulse with rdata = 0xDEAD_BEEF_0123_4567, err = 0, 4 cycles after gnt.
- Write with skewed channels: we = 1, be = 0x0F, wdata = 0x1122_3344_5566_7788; aw_ready delayed 3 cycles, w_ready = 1 → w_valid drops after 1 cycle, aw_valid after 3. b_ready rises only after both. w_strb = 0x0F, w_last = 1, one rvalid pulse after B.
- Error responses: bresp = 2'b10 on a write → err = 1. rresp = 2'b11 on a read → err = 1 and rdata captured.
- Back-to-back: req held high for 3 requests (R, W, R) → gnt only in IDLE cycles. Exactly 3 rvalid pulses in order, never two outstanding AXI transactions.
- Backpressure: r_valid delayed 10 cycles, a second req is held → no second gnt until after the first completes. ar_valid not reasserted.
- Reset mid-op: assert rst during WR_REQ with aw_valid = 1 → next cycle all valids/readies are 0 and the FSM is IDLE. No rvalid, and a new request is accepted normally afterward.
